// File: rtl/sample_iterator.sv
// Raster-walks an accepted bounding box, emitting SAMPS x-adjacent sample positions
// per beat alongside the triangle and colour they belong to.
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  input  logic        [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  input  logic signed [1:0][1:0][SIGFIG-1:0]            box_R14S,
  input  logic        [SIGFIG-1:0]                      step_R14U,
  input  logic                                          validTri_R14H,
  output logic                                          readyTri_R14H,
  input  logic                                          halt_R16H,
  output logic signed [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R16S,
  output logic        [COLORS-1:0][SIGFIG-1:0]          color_R16U,
  output logic signed [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_R16S,
  output logic        [SAMPS-1:0]                       validSamp_R16H
);

  localparam int W2 = SIGFIG + 2;

  if (RADIX >= SIGFIG || SAMPS < 1) begin : gBadParams
    $error("sample_iterator: RADIX must be below SIGFIG and SAMPS at least 1");
  end

  typedef enum logic {
    WAIT,
    TEST
  } state_t;

  state_t                                        state_q;
  logic        [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic        [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic        [1:0][SAMPS-1:0][SIGFIG-1:0]      sample_q;
  logic        [SAMPS-1:0]                       valid_q;
  logic        [SIGFIG-1:0]                      x_q;
  logic        [SIGFIG-1:0]                      y_q;
  logic        [SIGFIG-1:0]                      llX_q;
  logic        [SIGFIG-1:0]                      urX_q;
  logic        [SIGFIG-1:0]                      urY_q;
  logic        [SIGFIG-1:0]                      step_q;

  logic signed [W2-1:0] laneX_d [SAMPS];
  logic signed [W2-1:0] nextX_d;
  logic signed [W2-1:0] nextY_d;
  logic signed [W2-1:0] stepExt;
  logic                 rowEnd;
  logic                 lastRow;
  logic                 accept;
  logic                 emptyBox;

  function automatic logic signed [W2-1:0] ext(input logic [SIGFIG-1:0] v);
    return {{2{v[SIGFIG-1]}}, v};
  endfunction

  assign readyTri_R14H = rst && (state_q == WAIT);
  assign accept        = validTri_R14H && readyTri_R14H;
  assign emptyBox      = (ext(box_R14S[1][0]) < ext(box_R14S[0][0])) ||
                         (ext(box_R14S[1][1]) < ext(box_R14S[0][1]));

  // Widened lane positions so the comparisons against the upper-right corner never wrap.
  always_comb begin
    stepExt    = {2'b00, step_q};
    laneX_d[0] = ext(x_q);
    for (int s = 1; s < SAMPS; s++) begin
      laneX_d[s] = laneX_d[s-1] + stepExt;
    end
    nextX_d = laneX_d[SAMPS-1] + stepExt;
    nextY_d = ext(y_q) + stepExt;
    rowEnd  = nextX_d > ext(urX_q);
    lastRow = nextY_d > ext(urY_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= WAIT;
      tri_q    <= '0;
      color_q  <= '0;
      sample_q <= '0;
      valid_q  <= '0;
      x_q      <= '0;
      y_q      <= '0;
      llX_q    <= '0;
      urX_q    <= '0;
      urY_q    <= '0;
      step_q   <= '0;
    end else begin
      if (!halt_R16H) begin
        if (state_q == TEST) begin
          for (int s = 0; s < SAMPS; s++) begin
            sample_q[0][s] <= laneX_d[s][SIGFIG-1:0];
            sample_q[1][s] <= y_q;
            valid_q[s]     <= laneX_d[s] <= ext(urX_q);
          end
          if (rowEnd) begin
            x_q <= llX_q;
            y_q <= nextY_d[SIGFIG-1:0];
            if (lastRow) begin
              state_q <= WAIT;
            end
          end else begin
            x_q <= nextX_d[SIGFIG-1:0];
          end
        end else begin
          valid_q <= '0;
        end
      end
      // Acceptance only happens in WAIT, so it never collides with the walk above.
      if (accept) begin
        tri_q   <= tri_R14S;
        color_q <= color_R14U;
        llX_q   <= box_R14S[0][0];
        urX_q   <= box_R14S[1][0];
        urY_q   <= box_R14S[1][1];
        step_q  <= step_R14U;
        x_q     <= box_R14S[0][0];
        y_q     <= box_R14S[0][1];
        state_q <= emptyBox ? WAIT : TEST;
      end
    end
  end

  assign tri_R16S       = tri_q;
  assign color_R16U     = color_q;
  assign sample_R16S    = sample_q;
  assign validSamp_R16H = valid_q;

endmodule

// File: tb/tb_sample_iterator.sv
// Directed, table-driven bench for sample_iterator: box vectors with hand-computed
// beats, plus halt, overlapping-offer and mid-box reset sequences.
module tb_sample_iterator;

  localparam int SIGFIG = 24;
  localparam int SAMPS  = 4;

  logic                               clk;
  logic                               rst;
  logic signed [2:0][2:0][SIGFIG-1:0] triIn;
  logic        [2:0][SIGFIG-1:0]      colorIn;
  logic signed [1:0][1:0][SIGFIG-1:0] boxIn;
  logic        [SIGFIG-1:0]           stepIn;
  logic                               validTri;
  logic                               readyTri;
  logic                               halt;
  logic signed [2:0][2:0][SIGFIG-1:0] triOut;
  logic        [2:0][SIGFIG-1:0]      colorOut;
  logic signed [1:0][SAMPS-1:0][SIGFIG-1:0] sampleOut;
  logic        [SAMPS-1:0]            validSamp;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    int llx;
    int lly;
    int urx;
    int ury;
    int step;
    int firstBeat;
    int nBeats;
  } boxVec_t;

  typedef struct {
    int         x0;
    int         y;
    logic [3:0] valid;
  } beatVec_t;

  boxVec_t  boxTab  [5];
  beatVec_t beatTab [9];

  sample_iterator #(
    .SIGFIG(SIGFIG), .RADIX(10), .VERTS(3), .AXIS(3), .COLORS(3), .SAMPS(SAMPS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tri_R14S      (triIn),
    .color_R14U    (colorIn),
    .box_R14S      (boxIn),
    .step_R14U     (stepIn),
    .validTri_R14H (validTri),
    .readyTri_R14H (readyTri),
    .halt_R16H     (halt),
    .tri_R16S      (triOut),
    .color_R16U    (colorOut),
    .sample_R16S   (sampleOut),
    .validSamp_R16H(validSamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [255:0] act, input logic [255:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives box idx on the upstream port with validTri raised; does not wait.
  task automatic applyStimulus(input int idx);
    for (int v = 0; v < 3; v++) begin
      for (int a = 0; a < 3; a++) begin
        triIn[v][a] = 24'(idx * 1000 + v * 10 + a + 1);
      end
    end
    for (int c = 0; c < 3; c++) begin
      colorIn[c] = 24'(idx * 7 + c + 1);
    end
    boxIn[0][0] = 24'(boxTab[idx].llx);
    boxIn[0][1] = 24'(boxTab[idx].lly);
    boxIn[1][0] = 24'(boxTab[idx].urx);
    boxIn[1][1] = 24'(boxTab[idx].ury);
    stepIn      = 24'(boxTab[idx].step);
    validTri    = 1'b1;
  endtask

  task automatic checkBeat(input string tag, input int b, input int step);
    logic [SIGFIG-1:0] ex;
    checkOutput({tag, ".valid"}, 256'(validSamp), 256'(beatTab[b].valid));
    for (int s = 0; s < SAMPS; s++) begin
      ex = 24'(beatTab[b].x0 + s * step);
      checkOutput($sformatf("%s.x%0d", tag, s), 256'(sampleOut[0][s]), 256'(ex));
      ex = 24'(beatTab[b].y);
      checkOutput($sformatf("%s.y%0d", tag, s), 256'(sampleOut[1][s]), 256'(ex));
    end
  endtask

  task automatic runBox(input int idx);
    int waited;
    string tag;
    waited = 0;
    while (!readyTri && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput($sformatf("box%0d.readyBeforeOffer", idx), 256'(readyTri), 256'(1));
    applyStimulus(idx);
    @(posedge clk); #1;
    validTri = 1'b0;
    checkOutput($sformatf("box%0d.validAfterAccept", idx), 256'(validSamp), 256'(0));
    checkOutput($sformatf("box%0d.readyAfterAccept", idx), 256'(readyTri),
                256'(boxTab[idx].nBeats == 0));
    for (int b = 0; b < boxTab[idx].nBeats; b++) begin
      @(posedge clk); #1;
      tag = $sformatf("box%0d.beat%0d", idx, b);
      checkBeat(tag, boxTab[idx].firstBeat + b, boxTab[idx].step);
      if (b == 0) begin
        checkOutput({tag, ".tri"}, 256'(triOut), 256'(triIn));
        checkOutput({tag, ".color"}, 256'(colorOut), 256'(colorIn));
      end
    end
    checkOutput($sformatf("box%0d.readyAfterLast", idx), 256'(readyTri), 256'(1));
    @(posedge clk); #1;
    checkOutput($sformatf("box%0d.idleValid", idx), 256'(validSamp), 256'(0));
  endtask

  initial begin
    boxTab[0] = '{llx: 0,     lly: 0,    urx: 3072, ury: 1024, step: 1024, firstBeat: 0, nBeats: 2};
    boxTab[1] = '{llx: 0,     lly: 0,    urx: 4096, ury: 0,    step: 1024, firstBeat: 2, nBeats: 2};
    boxTab[2] = '{llx: 2048,  lly: 2048, urx: 1024, ury: 4096, step: 1024, firstBeat: 4, nBeats: 0};
    boxTab[3] = '{llx: -1024, lly: 512,  urx: 1024, ury: 512,  step: 512,  firstBeat: 4, nBeats: 2};
    boxTab[4] = '{llx: 0,     lly: 0,    urx: 2048, ury: 2048, step: 1024, firstBeat: 6, nBeats: 3};
    beatTab[0] = '{x0: 0,     y: 0,    valid: 4'hF};
    beatTab[1] = '{x0: 0,     y: 1024, valid: 4'hF};
    beatTab[2] = '{x0: 0,     y: 0,    valid: 4'hF};
    beatTab[3] = '{x0: 4096,  y: 0,    valid: 4'h1};
    beatTab[4] = '{x0: -1024, y: 512,  valid: 4'hF};
    beatTab[5] = '{x0: 1024,  y: 512,  valid: 4'h1};
    beatTab[6] = '{x0: 0,     y: 0,    valid: 4'h7};
    beatTab[7] = '{x0: 0,     y: 1024, valid: 4'h7};
    beatTab[8] = '{x0: 0,     y: 2048, valid: 4'h7};

    rst      = 1'b0;
    halt     = 1'b0;
    validTri = 1'b0;
    triIn    = '0;
    colorIn  = '0;
    boxIn    = '0;
    stepIn   = '0;
    #1;
    checkOutput("reset.ready", 256'(readyTri), 256'(0));
    checkOutput("reset.valid", 256'(validSamp), 256'(0));
    checkOutput("reset.sample", 256'(sampleOut), 256'(0));
    checkOutput("reset.tri", 256'(triOut), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("release.ready", 256'(readyTri), 256'(1));

    for (int i = 0; i < 5; i++) begin
      runBox(i);
    end

    // Halt for three edges after the first beat of box 0.
    applyStimulus(0);
    @(posedge clk); #1;
    validTri = 1'b0;
    @(posedge clk); #1;
    checkBeat("halt.beat0", 0, 1024);
    halt = 1'b1;
    for (int h = 0; h < 3; h++) begin
      @(posedge clk); #1;
      checkBeat($sformatf("halt.frozen%0d", h), 0, 1024);
    end
    halt = 1'b0;
    @(posedge clk); #1;
    checkBeat("halt.beat1", 1, 1024);
    checkOutput("halt.readyAfterLast", 256'(readyTri), 256'(1));
    @(posedge clk); #1;
    checkOutput("halt.idleValid", 256'(validSamp), 256'(0));

    // A second box offered while box 0 is in flight waits for WAIT.
    applyStimulus(0);
    @(posedge clk); #1;
    applyStimulus(1);
    checkOutput("overlap.readyBusy0", 256'(readyTri), 256'(0));
    @(posedge clk); #1;
    checkBeat("overlap.a0", 0, 1024);
    checkOutput("overlap.readyBusy1", 256'(readyTri), 256'(0));
    checkOutput("overlap.triStillA", 256'(triOut[0][0]), 256'(24'd1));
    @(posedge clk); #1;
    checkBeat("overlap.a1", 1, 1024);
    checkOutput("overlap.readyFree", 256'(readyTri), 256'(1));
    @(posedge clk); #1;
    validTri = 1'b0;
    checkOutput("overlap.gapValid", 256'(validSamp), 256'(0));
    checkOutput("overlap.readyTaken", 256'(readyTri), 256'(0));
    checkOutput("overlap.triB", 256'(triOut), 256'(triIn));
    @(posedge clk); #1;
    checkBeat("overlap.b0", 2, 1024);
    @(posedge clk); #1;
    checkBeat("overlap.b1", 3, 1024);
    @(posedge clk); #1;
    checkOutput("overlap.idleValid", 256'(validSamp), 256'(0));

    // Asynchronous reset in the middle of box 4.
    applyStimulus(4);
    @(posedge clk); #1;
    validTri = 1'b0;
    @(posedge clk); #1;
    checkBeat("rstmid.beat0", 6, 1024);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("rstmid.valid", 256'(validSamp), 256'(0));
    checkOutput("rstmid.ready", 256'(readyTri), 256'(0));
    checkOutput("rstmid.sample", 256'(sampleOut), 256'(0));
    checkOutput("rstmid.tri", 256'(triOut), 256'(0));
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstmid.readyRelease", 256'(readyTri), 256'(1));
    runBox(0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/sample_iterator.md
Name: sample_iterator

Overview:
- Produces the sample stream that the sample-test stage consumes.
- Accepts one triangle plus its bounding box from the bounding-box stage, then walks the box in raster order: x-major within a row, rows bottom to top.
- Emits SAMPS horizontally adjacent sample locations per cycle with per-lane valid flags, and forwards the triangle and colour unchanged alongside every beat.
- Honours a halt from downstream and back-pressures upstream while a box is in flight.

Parameters:
- SIGFIG, 24, bits in position and colour words.
- RADIX, 10, fraction bits (1.0 = 1024).
- VERTS, 3, vertices per triangle.
- AXIS, 3, axes per vertex (x, y, z).
- COLORS, 3, colour channels.
- SAMPS, 4, samples emitted per cycle (lanes along x).

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-low reset.
- tri_R14S, in, [VERTS][AXIS] x SIGFIG signed, triangle.
- color_R14U, in, [COLORS] x SIGFIG unsigned, triangle colour.
- box_R14S, in, [2][2] x SIGFIG signed, [0]=lower-left, [1]=upper-right, inner index [0]=x, [1]=y; corners are inclusive.
- step_R14U, in, SIGFIG unsigned, sample spacing (>0).
- validTri_R14H, in, 1, upstream offers a box this cycle.
- readyTri_R14H, out, 1, iterator can accept a box.
- halt_R16H, in, 1, downstream stall.
- tri_R16S, out, as tri_R14S, registered triangle.
- color_R16U, out, as color_R14U, registered colour.
- sample_R16S, out, [2][SAMPS] x SIGFIG signed, sample x/y per lane.
- validSamp_R16H, out, [SAMPS] x 1, lane holds a real sample.

Behaviour:
- Reset (rst=0, async): state=WAIT; all outputs and internal x/y/box/step registers = 0; readyTri_R14H=0 while in reset.
- readyTri_R14H = (state==WAIT). The output is combinational from state only and does not depend on halt.
- Acceptance:
  - Occurs at a clock edge where validTri_R14H && readyTri_R14H.
  - Latches tri, color, box and step.
  - Sets x=ll_x, y=ll_y and state=TEST.
  - tri_R16S and color_R16U update at this edge and hold until the next acceptance.
- Empty box: if ur_x<ll_x or ur_y<ll_y at acceptance, state stays WAIT and no beat is emitted.
- TEST, on each edge with halt_R16H=0:
  - Lane s: sample_R16S[0][s] = x + s*step; sample_R16S[1][s] = y; validSamp_R16H[s] = (x + s*step <= ur_x).
  - Row advance: if x + SAMPS*step > ur_x, then x=ll_x and y=y+step; otherwise x = x + SAMPS*step.
  - Last beat: if the row ends and y+step > ur_y, state=WAIT.
- WAIT, on each edge with halt_R16H=0: validSamp_R16H all 0. Sample positions hold their last value and are don't-care.
- halt_R16H=1: every R16 output register and the x/y/state registers hold their values; acceptance is still permitted if state==WAIT.
- Latency: the first beat is visible after the first unhalted edge following acceptance. Beats are back-to-back while unhalted. A box of C columns and R rows takes ceil(C/SAMPS)*R beats.
- Arithmetic:
  - Lane x and next-x/next-y are computed in SIGFIG+2 bits signed, so comparisons against ur never wrap.
  - Stored x/y are SIGFIG bits.
  - The upstream stage guarantees ur + SAMPS*step is representable.
- Reset asserted mid-box: the box is abandoned and all outputs return to 0 immediately.

Test Plan:
- SAMPS=4, step=1024, box ll=(0,0), ur=(3072,1024) -> exactly 2 beats, all 4 lanes valid each beat.
  - Beat 1: x = 0, 1024, 2048, 3072; y = 0.
  - Beat 2: same x values; y = 1024.
  - readyTri_R14H high again on the edge after beat 2.
- Box ur=(4096,0), same step -> beat 1 has lanes 0-3 valid; beat 2 has only lane 0 valid, at x=4096; total 2 beats.
- Box ll=(2048,2048), ur=(1024,4096) (empty) -> no beat issued; readyTri_R14H stays 1.
- First scenario with halt_R16H=1 for 3 cycles after beat 1 -> beat 1 outputs frozen for 3 cycles, beat 2 follows the first unhalted edge, no sample lost or duplicated.
- Offer a second box while the first is in flight -> readyTri_R14H=0 and the second box is not taken. It is accepted the cycle state returns to WAIT, and its first beat follows directly after the first box's last beat plus one edge.
- Assert rst=0 mid-box -> validSamp_R16H all 0 and readyTri_R14H=0 asynchronously. After release, readyTri_R14H=1 and a new box iterates from its ll corner.
